nn_result_tx: RTL and testbench

- Result-return path of the NN serial link.
- When nn_core raises nn_finish, this block reads O_NUM result words from the output memory (opm) through the base/offset read port.
- It frames the words as header, payload bytes and XOR checksum, and sends them on txd as 8N1 UART, LSB first.
- It is the transmitting counterpart of the host-side command receiver and sits beside SCI_IO under nn.

---
 rtl/nn_result_tx.sv | 211 +++++++++++++++++++++
 tb/tb_nn_result_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_result_tx.sv
// nn_result_tx -- result-return path of the NN serial link.
//
// When nn_core signals completion (rising edge of i_nn_finish), the block reads
// O_NUM result words from the output memory (opm) through its base/offset read port.
// It sends them on o_txd as 8N1 UART bytes, LSB first, in this frame:
//   HDR, payload bytes (MSB byte of each word first), XOR checksum of payload.
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a 0->1 edge on i_nn_finish
// HDR   | sending the header byte
// RDREQ | presenting opm_offset = word index (txd idle)
// RDLAT | opm_dout valid; capture word, start its first byte (txd idle)
// DATA  | sending payload bytes of the current word, back-to-back
// CSUM  | sending the checksum byte
// DONE  | one-cycle tx_done pulse, busy already low
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_nn_finish       inference-complete level; rising edge starts a frame
//   i_res_base        opm base address of the result vector, latched at start
//   o_opm_base        opm read base address
//   o_opm_offset      opm read offset (word index)
//   i_opm_dout        opm read data, valid 1 cycle after base/offset
//   o_txd             UART serial output, idle high
//   o_tx_busy         high from frame start through the last stop bit
//   o_tx_done         one-cycle pulse after the checksum stop bit
module nn_result_tx #(
  parameter int          D_LEN     = 16,
  parameter int          DA_AWIDTH = 8,
  parameter int          OFS_WIDTH = 4,
  parameter int          O_NUM     = 10,
  parameter int          CLK_DIV   = 434,
  parameter logic [7:0]  HDR       = 8'hA5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_nn_finish,
  input  logic [DA_AWIDTH-1:0] i_res_base,
  output logic [DA_AWIDTH-1:0] o_opm_base,
  output logic [OFS_WIDTH-1:0] o_opm_offset,
  input  logic [D_LEN-1:0]     i_opm_dout,
  output logic                 o_txd,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int NB    = D_LEN / 8;
  localparam int BI_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [BI_W-1:0]      LAST_BYTE = BI_W'(NB - 1);
  localparam logic [OFS_WIDTH-1:0] LAST_WORD = OFS_WIDTH'(O_NUM - 1);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RDREQ,
    S_RDLAT,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_fin_q;
  logic                   r_txd;
  logic                   r_tx_busy;
  logic                   r_tx_done;
  logic [DA_AWIDTH-1:0]   r_opm_base;
  logic [OFS_WIDTH-1:0]   r_opm_offset;
  logic [OFS_WIDTH-1:0]   r_word_idx;
  logic [BI_W-1:0]        r_byte_idx;
  logic [D_LEN-1:0]       r_word;
  logic [7:0]             r_tx_byte;
  logic [7:0]             r_csum;
  logic [3:0]             r_bit_cnt;
  logic [DIV_W-1:0]       r_div_cnt;

  logic                   w_sending;
  logic                   w_byte_end;
  logic [7:0]             w_first_byte;
  logic [7:0]             w_next_byte;

  assign w_sending    = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
  // Last cycle of the stop bit: the next byte (or state) takes over on the following cycle.
  assign w_byte_end   = w_sending && (r_bit_cnt == 4'd9) && (r_div_cnt == DIV_LAST);
  assign w_first_byte = i_opm_dout[D_LEN-1 -: 8];
  assign w_next_byte  = r_word[D_LEN-1 -: 8];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_fin_q      <= 1'b0;
      r_txd        <= 1'b1;
      r_tx_busy    <= 1'b0;
      r_tx_done    <= 1'b0;
      r_opm_base   <= '0;
      r_opm_offset <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_tx_byte    <= '0;
      r_csum       <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
    end else begin
      r_fin_q   <= i_nn_finish;
      r_tx_done <= 1'b0;

      // Bit timing within a byte; byte boundaries are handled by the state case below.
      if (w_sending && !w_byte_end) begin
        if (r_div_cnt == DIV_LAST) begin
          r_div_cnt <= '0;
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd8) begin
            r_txd <= 1'b1;
          end else begin
            r_txd     <= r_tx_byte[0];
            r_tx_byte <= r_tx_byte >> 1;
          end
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_nn_finish && !r_fin_q) begin
            r_opm_base <= i_res_base;
            r_word_idx <= '0;
            r_csum     <= '0;
            r_tx_busy  <= 1'b1;
            r_txd      <= 1'b0;
            r_tx_byte  <= HDR;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_state    <= S_HDR;
          end
        end

        S_HDR: begin
          if (w_byte_end) begin
            r_txd        <= 1'b1;
            r_opm_offset <= r_word_idx;
            r_state      <= S_RDREQ;
          end
        end

        S_RDREQ: r_state <= S_RDLAT;

        // Read data is used directly so the start bit follows without a third idle cycle.
        S_RDLAT: begin
          r_word     <= i_opm_dout << 8;
          r_byte_idx <= '0;
          r_txd      <= 1'b0;
          r_tx_byte  <= w_first_byte;
          r_csum     <= r_csum ^ w_first_byte;
          r_bit_cnt  <= '0;
          r_div_cnt  <= '0;
          r_state    <= S_DATA;
        end

        S_DATA: begin
          if (w_byte_end) begin
            if (r_byte_idx != LAST_BYTE) begin
              r_byte_idx <= r_byte_idx + BI_W'(1);
              r_word     <= r_word << 8;
              r_txd      <= 1'b0;
              r_tx_byte  <= w_next_byte;
              r_csum     <= r_csum ^ w_next_byte;
              r_bit_cnt  <= '0;
              r_div_cnt  <= '0;
            end else if (r_word_idx != LAST_WORD) begin
              r_word_idx   <= r_word_idx + OFS_WIDTH'(1);
              r_opm_offset <= r_word_idx + OFS_WIDTH'(1);
              r_txd        <= 1'b1;
              r_state      <= S_RDREQ;
            end else begin
              r_txd     <= 1'b0;
              r_tx_byte <= r_csum;
              r_bit_cnt <= '0;
              r_div_cnt <= '0;
              r_state   <= S_CSUM;
            end
          end
        end

        S_CSUM: begin
          if (w_byte_end) begin
            r_txd     <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b1;
            r_state   <= S_DONE;
          end
        end

        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_opm_base   = r_opm_base;
  assign o_opm_offset = r_opm_offset;
  assign o_txd        = r_txd;
  assign o_tx_busy    = r_tx_busy;
  assign o_tx_done    = r_tx_done;

endmodule

// File: tb/tb_nn_result_tx.sv
// tb_nn_result_tx -- directed bench for nn_result_tx.
//
// Four instances with different geometries share clock, reset, res_base and a
// word table that models the opm (registered read, 1-cycle latency):
//   0: CLK_DIV=4, O_NUM=2,  D_LEN=16   basic frame, retrigger, level, mid-frame reset
//   1: CLK_DIV=4, O_NUM=1,  D_LEN=8    smallest frame
//   2: CLK_DIV=2, O_NUM=16, D_LEN=8    full offset range
//   3: CLK_DIV=2, O_NUM=3,  D_LEN=16   end-to-end timing
// A UART receiver task decodes o_txd, checking byte values, bit widths and idle gaps.
module tb_nn_result_tx;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           fin;
  logic [7:0]           res_base;
  logic [3:0]           txd_v, busy_v, done_v;
  logic [3:0][7:0]      base_v;
  logic [3:0][3:0]      off_v;
  logic [15:0]          dout_a, dout_d;
  logic [7:0]           dout_b, dout_c;
  logic [15:0]          wtab [16];
  logic [7:0]           exp_b [0:40];
  int                   exp_g [0:40];
  int                   nexp;
  int                   cyc = 0;
  int                   dcnt [4];
  int                   total = 0;
  int                   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    dout_a <= wtab[off_v[0]];
    dout_b <= wtab[off_v[1]][7:0];
    dout_c <= wtab[off_v[2]][7:0];
    dout_d <= wtab[off_v[3]];
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (done_v[i] === 1'b1) dcnt[i] = dcnt[i] + 1;
  end

  nn_result_tx #(.D_LEN(16), .O_NUM(2), .CLK_DIV(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_nn_finish(fin[0]), .i_res_base(res_base),
    .o_opm_base(base_v[0]), .o_opm_offset(off_v[0]), .i_opm_dout(dout_a),
    .o_txd(txd_v[0]), .o_tx_busy(busy_v[0]), .o_tx_done(done_v[0]));

  nn_result_tx #(.D_LEN(8), .O_NUM(1), .CLK_DIV(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_nn_finish(fin[1]), .i_res_base(res_base),
    .o_opm_base(base_v[1]), .o_opm_offset(off_v[1]), .i_opm_dout(dout_b),
    .o_txd(txd_v[1]), .o_tx_busy(busy_v[1]), .o_tx_done(done_v[1]));

  nn_result_tx #(.D_LEN(8), .O_NUM(16), .CLK_DIV(2)) u_c (
    .i_clk(clk), .i_rst(rst), .i_nn_finish(fin[2]), .i_res_base(res_base),
    .o_opm_base(base_v[2]), .o_opm_offset(off_v[2]), .i_opm_dout(dout_c),
    .o_txd(txd_v[2]), .o_tx_busy(busy_v[2]), .o_tx_done(done_v[2]));

  nn_result_tx #(.D_LEN(16), .O_NUM(3), .CLK_DIV(2)) u_d (
    .i_clk(clk), .i_rst(rst), .i_nn_finish(fin[3]), .i_res_base(res_base),
    .o_opm_base(base_v[3]), .o_opm_offset(off_v[3]), .i_opm_dout(dout_d),
    .o_txd(txd_v[3]), .o_tx_busy(busy_v[3]), .o_tx_done(done_v[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected frame from the word table: header, payload MSB byte first, XOR checksum.
  // A new word is preceded by two idle cycles; everything else is back-to-back.
  task automatic build_exp(input int o, input int nb);
    logic [7:0] cs;
    logic [7:0] by;
    int p;
    cs = 8'h00;
    exp_b[0] = 8'hA5;
    exp_g[0] = 0;
    p = 1;
    for (int w = 0; w < o; w++) begin
      for (int k = nb - 1; k >= 0; k--) begin
        by = wtab[w][8*k +: 8];
        exp_b[p] = by;
        exp_g[p] = (k == nb - 1) ? 2 : 0;
        cs = cs ^ by;
        p++;
      end
    end
    exp_b[p] = cs;
    exp_g[p] = 0;
    nexp = p + 1;
  endtask

  // Receive one byte: count idle cycles before the start bit, then sample every
  // cycle of the 10 bit periods; a bit that changes inside its period is a shape error.
  task automatic rx_byte(input int sel, input int cdiv, output logic [7:0] b, output int gap,
                         output int sbad, output logic tmo, output int ts);
    logic [9:0] bits;
    logic       v0;
    b = '0; gap = 0; sbad = 0; tmo = 1'b0; ts = 0; bits = '0; v0 = 1'b0;
    @(negedge clk);
    while (txd_v[sel] !== 1'b0) begin
      gap++;
      if (gap > 40 * cdiv) begin
        tmo = 1'b1;
        return;
      end
      @(negedge clk);
    end
    ts = cyc;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < cdiv; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        if (j == 0) begin
          v0 = txd_v[sel];
          bits[k] = v0;
        end else if (txd_v[sel] !== v0) begin
          sbad++;
        end
      end
    end
    if (bits[0] !== 1'b0) sbad++;
    if (bits[9] !== 1'b1) sbad++;
    b = bits[8:1];
  endtask

  task automatic rx_frame(input int sel, input int cdiv, input int tot_cyc, input string tag);
    logic [7:0] rb;
    int gap, sb, ts, t0;
    logic tmo;
    t0 = 0;
    for (int p = 0; p < nexp; p++) begin
      rx_byte(sel, cdiv, rb, gap, sb, tmo, ts);
      chk($sformatf("%s_tmo%0d", tag, p), {31'b0, tmo}, 32'd0);
      if (tmo) return;
      if (p == 0) t0 = ts;
      chk($sformatf("%s_byte%0d", tag, p), {24'b0, rb}, {24'b0, exp_b[p]});
      chk($sformatf("%s_gap%0d", tag, p), gap, exp_g[p]);
      chk($sformatf("%s_shape%0d", tag, p), sb, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, {31'b0, done_v[sel]}, 32'd1);
    chk({tag, "_busy_low"}, {31'b0, busy_v[sel]}, 32'd0);
    chk({tag, "_cycles"}, cyc - t0, tot_cyc);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, done_v[sel]}, 32'd0);
  endtask

  task automatic quiet(input int sel, input int n, input string tag);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd_v[sel] !== 1'b1) lows++;
    end
    chk({tag, "_quiet"}, lows, 32'd0);
  endtask

  task automatic load_a_frame();
    exp_b[0] = 8'hA5; exp_g[0] = 0;
    exp_b[1] = 8'h12; exp_g[1] = 2;
    exp_b[2] = 8'h34; exp_g[2] = 0;
    exp_b[3] = 8'hAB; exp_g[3] = 2;
    exp_b[4] = 8'hCD; exp_g[4] = 0;
    exp_b[5] = 8'h40; exp_g[5] = 0;
    nexp = 6;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int gap, sb, ts;
    logic tmo;
    for (int i = 0; i < 4; i++) dcnt[i] = 0;
    for (int i = 0; i < 16; i++) wtab[i] = 16'h0000;
    rst = 1'b1;
    fin = 4'h0;
    res_base = 8'h10;
    wtab[0] = 16'h1234;
    wtab[1] = 16'hABCD;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_txd", {28'b0, txd_v}, 32'hF);
    chk("rst_busy", {28'b0, busy_v}, 32'h0);
    chk("rst_done", {28'b0, done_v}, 32'h0);
    chk("rst_base", {24'b0, base_v[0]}, 32'h0);
    chk("rst_off", {28'b0, off_v[0]}, 32'h0);

    // Basic frame; nn_finish raised 2 cycles after reset release, then
    // dropped and re-raised mid-frame, which must not start another frame.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    fin[0] = 1'b1;
    load_a_frame();
    fork
      rx_frame(0, 4, 244, "basic");
      begin
        repeat (60) @(negedge clk);
        fin[0] = 1'b0;
        repeat (20) @(negedge clk);
        fin[0] = 1'b1;
      end
    join
    chk("basic_base", {24'b0, base_v[0]}, 32'h10);
    chk("basic_off", {28'b0, off_v[0]}, 32'h1);
    quiet(0, 150, "retrig");
    chk("retrig_done_cnt", dcnt[0], 32'd1);

    // New edge after tx_done: second identical frame
    fin[0] = 1'b0;
    @(negedge clk);
    fin[0] = 1'b1;
    rx_frame(0, 4, 244, "second");
    repeat (4) @(negedge clk);
    chk("second_done_cnt", dcnt[0], 32'd2);

    // Reset during d2 of the second payload byte (8'h34, d2=1)
    fin[0] = 1'b0;
    @(negedge clk);
    fin[0] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rx_byte(0, 4, rb, gap, sb, tmo, ts);
      chk($sformatf("abort_byte%0d", p), {24'b0, rb}, {24'b0, exp_b[p]});
    end
    @(negedge clk);
    chk("abort_start", {31'b0, txd_v[0]}, 32'd0);
    repeat (13) @(negedge clk);
    chk("abort_d2", {31'b0, txd_v[0]}, 32'd1);
    rst = 1'b1;
    fin[0] = 1'b0;
    @(negedge clk);
    chk("abort_txd", {31'b0, txd_v[0]}, 32'd1);
    chk("abort_busy", {31'b0, busy_v[0]}, 32'd0);
    rst = 1'b0;
    quiet(0, 100, "abort");
    chk("abort_done_cnt", dcnt[0], 32'd2);
    fin[0] = 1'b1;
    rx_frame(0, 4, 244, "after_abort");
    repeat (4) @(negedge clk);
    chk("after_abort_done_cnt", dcnt[0], 32'd3);

    // Single 8-bit word of zero
    wtab[0] = 16'h5500;
    build_exp(1, 1);
    fin[1] = 1'b1;
    rx_frame(1, 4, 122, "onum1");

    // Sixteen 8-bit words: offsets 0..15 in order, no wrap
    res_base = 8'h3C;
    for (int i = 0; i < 16; i++) wtab[i] = {8'hEE, 4'(i), 4'(15 - i)};
    build_exp(16, 1);
    fin[2] = 1'b1;
    rx_frame(2, 2, 392, "onum16");
    chk("onum16_off", {28'b0, off_v[2]}, 32'd15);
    chk("onum16_base", {24'b0, base_v[2]}, 32'h3C);

    // Timing: CLK_DIV=2, O_NUM=3, D_LEN=16 -> 10*2*8 + 6 = 166 cycles
    wtab[0] = 16'hC3A5;
    wtab[1] = 16'h0F0F;
    wtab[2] = 16'h7E81;
    build_exp(3, 2);
    fin[3] = 1'b1;
    rx_frame(3, 2, 166, "timing");
    chk("timing_off", {28'b0, off_v[3]}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
